multi_port_mmu: RTL and testbench
=================================

MULTI_PORT_MMU -- requirements
Module: multi_port_mmu

Interface
REQ-001 Parameters SHALL be:
- NUM_PORTS, default 2: number of independent client ports, ≥1.
- BUS_WIDTH, default 8: data word width.
- ADDRESS_WIDTH, default 32: client address width.
- ROM_SIZE, default 256: ROM words, mapped at 0..ROM_SIZE-1.
- RAM_SIZE, default 512: RAM words, mapped at ROM_SIZE..ROM_SIZE+RAM_SIZE-1.
- ROM_FILE, default "": hex init file for ROM.

REQ-002 Ports SHALL be as follows; per-port buses are flattened with port p at slice [p*W +: W]:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_PORTS  access request per port.
- we  in  NUM_PORTS  1 = write, 0 = read.
- addr  in  NUM_PORTS*ADDRESS_WIDTH  client address.
- wdata  in  NUM_PORTS*BUS_WIDTH  write data.
- rdata  out  NUM_PORTS*BUS_WIDTH  read data.
- busy  out  NUM_PORTS  access in flight.
- done  out  NUM_PORTS  one-cycle completion pulse.
- fault  out  NUM_PORTS  completed access was illegal.

Function
REQ-003 Each port SHALL run its own FSM with states IDLE, ROM_WAIT, RAM_WAIT, RESP.
REQ-004 In IDLE or RESP, req=1 SHALL be accepted at the rising edge, latching addr, we and wdata for that port.
REQ-005 On acceptance, the port SHALL move to RESP with fault=1 if addr ≥ ROM_SIZE+RAM_SIZE, or if we=1 and addr < ROM_SIZE; no memory SHALL be modified.
REQ-006 Otherwise, on acceptance, the port SHALL move to ROM_WAIT if addr < ROM_SIZE, else to RAM_WAIT, with fault=0.
REQ-007 ROM_WAIT SHALL move to RESP at the next edge, loading rdata with ROM[addr].
REQ-008 RAM_WAIT SHALL move to RESP at the edge where the port holds the RAM grant, performing the access on RAM index addr-ROM_SIZE.
REQ-009 A granted read SHALL load rdata with the addressed word; a granted write SHALL store wdata and leave rdata unchanged.
REQ-010 RESP with req=0 SHALL move to IDLE.
REQ-011 Outputs SHALL be decoded from state: busy=1 in ROM_WAIT or RAM_WAIT; done=1 in RESP only.
REQ-012 rdata and fault SHALL hold their values until the port's next completion.
REQ-013 Latency SHALL be counted from the accepting edge E0:
- illegal access: done visible after E0;
- ROM access, or uncontended RAM access: done visible after E0+1;
- each cycle a RAM access loses arbitration adds one cycle.
REQ-014 The RAM SHALL be single-ported, performing exactly one access per cycle.
REQ-015 RAM arbitration SHALL be round-robin among ports in RAM_WAIT, starting from the index after the last granted port and wrapping.
REQ-016 The ROM SHALL serve all ports concurrently with no arbitration.
REQ-017 Address-to-port ordering SHALL follow grant order: a write granted before a read of the same word SHALL be visible to that read.
REQ-018 When ROM_FILE is empty, the ROM SHALL be initialised with ROM[i] = i truncated to BUS_WIDTH.
REQ-019 RAM contents SHALL initialise to 0 in simulation and SHALL NOT be cleared by reset.
REQ-020 Changes to req, addr, we or wdata while busy=1 SHALL be ignored.

Reset
REQ-021 While reset=0, immediately and without a clock edge, every port SHALL be in IDLE with busy=0, done=0, fault=0 and rdata=0.
REQ-022 While reset=0, the round-robin pointer SHALL be set so that port 0 has the highest priority.
REQ-023 An access in flight when reset asserts SHALL be abandoned, and an ungranted RAM write SHALL NOT modify the RAM.
REQ-024 The first edge with reset=1 SHALL be able to accept requests.

Verification
REQ-025 The bench SHALL cover these directed scenarios, using default parameters:
- Port 0 reads 0x10 at E0 -> busy=1 after E0; done=1, rdata=0x10, fault=0 after E0+1; IDLE afterwards.
- Port 1 writes 0xA5 to 0x105, then port 0 reads 0x105 -> rdata=0xA5 (RAM index 5); port 1 rdata unchanged.
- Both ports issue RAM reads at the same edge after reset -> port 0 done after E0+1, port 1 done after E0+2; a repeat simultaneous pair completes port 1 first.
- Port 0 writes to 0x20 -> done=1, fault=1 after E0, ROM unchanged; read of 0x300 -> fault=1; read of 0x2FF -> fault=0.
- reset pulled low while port 1 is in RAM_WAIT for a write to 0x180 -> busy/done/fault/rdata go 0 asynchronously; a later read of 0x180 returns its old value.
- Port 0 holds req=1 reading ROM continuously -> done asserts every second cycle, accepted on each RESP cycle, addresses advance as driven.

Source files
------------

// File: rtl/multi_port_mmu_if.sv
// multi_port_mmu_if: client-side bus of the multi-port MMU.
// All per-port fields are flattened, port p at slice [p*W +: W].
//   req   : access request per port
//   we    : 1 = write, 0 = read
//   addr  : client address
//   wdata : write data
//   rdata : read data (holds until the port's next completion)
//   busy  : access in flight (ROM_WAIT / RAM_WAIT)
//   done  : one-cycle completion pulse (RESP)
//   fault : last completed access was illegal
// master = client side, slave = MMU side.
interface multi_port_mmu_if #(
  parameter int NUM_PORTS     = 2,
  parameter int BUS_WIDTH     = 8,
  parameter int ADDRESS_WIDTH = 32
);
  logic [NUM_PORTS-1:0]               req;
  logic [NUM_PORTS-1:0]               we;
  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] addr;
  logic [NUM_PORTS*BUS_WIDTH-1:0]     wdata;
  logic [NUM_PORTS*BUS_WIDTH-1:0]     rdata;
  logic [NUM_PORTS-1:0]               busy;
  logic [NUM_PORTS-1:0]               done;
  logic [NUM_PORTS-1:0]               fault;

  modport master (output req, we, addr, wdata, input rdata, busy, done, fault);
  modport slave  (input req, we, addr, wdata, output rdata, busy, done, fault);
endinterface

// File: rtl/multi_port_mmu.sv
// multi_port_mmu: NUM_PORTS independent clients sharing a ROM (read-only,
// served to every port in parallel) and a single-ported RAM (one access per
// cycle, round-robin arbitrated). Address map: ROM at 0..ROM_SIZE-1, RAM at
// ROM_SIZE..ROM_SIZE+RAM_SIZE-1; anything above, or a write into ROM, faults.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : multi_port_mmu_if.slave (req/we/addr/wdata in, rdata/busy/done/fault out)
module multi_port_mmu #(
  parameter int    NUM_PORTS     = 2,
  parameter int    BUS_WIDTH     = 8,
  parameter int    ADDRESS_WIDTH = 32,
  parameter int    ROM_SIZE      = 256,
  parameter int    RAM_SIZE      = 512,
  parameter string ROM_FILE      = ""
) (
  input  logic             clk,
  input  logic             reset,
  multi_port_mmu_if.slave  bus
);
  localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int ROM_IW = (ROM_SIZE > 1) ? $clog2(ROM_SIZE) : 1;
  localparam int RAM_IW = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] ROM_END = ADDRESS_WIDTH'(ROM_SIZE);
  localparam logic [ADDRESS_WIDTH-1:0] MEM_END = ADDRESS_WIDTH'(ROM_SIZE + RAM_SIZE);
  localparam logic [PW-1:0]            LAST_P  = PW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ROM_WAIT, S_RAM_WAIT, S_RESP} state_e;
  typedef logic [ROM_SIZE-1:0][BUS_WIDTH-1:0] rom_img_t;

  // ROM image: identity pattern.
  function automatic rom_img_t rom_load();
    rom_img_t r;
    for (int i = 0; i < ROM_SIZE; i++) r[i] = BUS_WIDTH'(i);
    return r;
  endfunction

  rom_img_t             rom_mem = rom_load();
  // RAM is deliberately outside the reset domain; it only starts at zero.
  logic [BUS_WIDTH-1:0] ram_q [RAM_SIZE] = '{default: '0};

  logic [NUM_PORTS-1:0]              waiting, gnt, we_v;
  logic [NUM_PORTS-1:0][RAM_IW-1:0]  ram_idx_v;
  logic [NUM_PORTS-1:0][BUS_WIDTH-1:0] wdata_v;
  logic                              gnt_vld;
  logic [PW-1:0]                     gnt_idx, last_q, last_d;
  logic [BUS_WIDTH-1:0]              ram_rdata;

  // ---------------- per-port FSMs ----------------
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d, req_addr;
    logic                     we_q, we_d, req_we;
    logic [BUS_WIDTH-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
    logic                     fault_q, fault_d;

    assign req_addr = bus.addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign req_we   = bus.we[p];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= S_IDLE;
        addr_q  <= '0;
        we_q    <= 1'b0;
        wdata_q <= '0;
        rdata_q <= '0;
        fault_q <= 1'b0;
      end else begin
        state_q <= state_d;
        addr_q  <= addr_d;
        we_q    <= we_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
        fault_q <= fault_d;
      end
    end

    always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
      unique case (state_q)
        S_IDLE, S_RESP: begin
          if (bus.req[p]) begin
            addr_d  = req_addr;
            we_d    = req_we;
            wdata_d = bus.wdata[p*BUS_WIDTH +: BUS_WIDTH];
            if (req_addr >= MEM_END || (req_we && req_addr < ROM_END)) begin
              // Illegal: completes immediately, memories untouched.
              fault_d = 1'b1;
              state_d = S_RESP;
            end else begin
              // fault keeps its old value until this access completes.
              state_d = (req_addr < ROM_END) ? S_ROM_WAIT : S_RAM_WAIT;
            end
          end else if (state_q == S_RESP) begin
            state_d = S_IDLE;
          end
        end
        S_ROM_WAIT: begin
          rdata_d = rom_mem[ROM_IW'(addr_q)];
          fault_d = 1'b0;
          state_d = S_RESP;
        end
        S_RAM_WAIT: begin
          if (gnt[p]) begin
            if (!we_q) rdata_d = ram_rdata;
            fault_d = 1'b0;
            state_d = S_RESP;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    assign waiting[p]   = (state_q == S_RAM_WAIT);
    assign we_v[p]      = we_q;
    assign wdata_v[p]   = wdata_q;
    assign ram_idx_v[p] = RAM_IW'(addr_q - ROM_END);

    assign bus.busy[p]  = (state_q == S_ROM_WAIT) || (state_q == S_RAM_WAIT);
    assign bus.done[p]  = (state_q == S_RESP);
    assign bus.fault[p] = fault_q;
    assign bus.rdata[p*BUS_WIDTH +: BUS_WIDTH] = rdata_q;
  end

  // ---------------- RAM arbiter ----------------
  // Search starts at the port after the last winner; reset leaves last_q at
  // the top index so port 0 is searched first.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(last_q) + k) % NUM_PORTS;
      if (!gnt_vld && waiting[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
    last_d = gnt_vld ? gnt_idx : last_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= LAST_P;
    else        last_q <= last_d;
  end

  // Single RAM port: the winner reads the current word or writes its data.
  // Grants come from registered state, so nothing in flight at reset can write.
  assign ram_rdata = ram_q[ram_idx_v[gnt_idx]];

  always_ff @(posedge clk) begin
    if (gnt_vld && we_v[gnt_idx]) ram_q[ram_idx_v[gnt_idx]] <= wdata_v[gnt_idx];
  end
endmodule

// File: tb/tb_multi_port_mmu.sv
// Directed bench for multi_port_mmu (default parameters, identity ROM).
// Inputs change on the falling edge; outputs are sampled 1ns after the rising
// edge. Observed port status is packed as {busy, done, fault, rdata}.
module tb_multi_port_mmu;
  localparam int NP = 2, BW = 8, AW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0, n_err = 0;

  multi_port_mmu_if #(.NUM_PORTS(NP), .BUS_WIDTH(BW), .ADDRESS_WIDTH(AW)) bus ();

  multi_port_mmu #(
    .NUM_PORTS(NP), .BUS_WIDTH(BW), .ADDRESS_WIDTH(AW),
    .ROM_SIZE(256), .RAM_SIZE(512), .ROM_FILE("")
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ob(input int p);
    return {21'b0, bus.busy[p], bus.done[p], bus.fault[p], bus.rdata[p*BW +: BW]};
  endfunction

  function automatic logic [31:0] ex(input logic b, input logic d, input logic f,
                                     input logic [BW-1:0] r);
    return {21'b0, b, d, f, r};
  endfunction

  task automatic drv(input int p, input logic rq, input logic w,
                     input logic [AW-1:0] a, input logic [BW-1:0] d);
    bus.req[p] = rq;
    bus.we[p]  = w;
    bus.addr[p*AW +: AW] = a;
    bus.wdata[p*BW +: BW] = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle request; returns 1ns after the accepting edge E0.
  task automatic access(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [BW-1:0] d);
    @(negedge clk);
    drv(p, 1'b1, w, a, d);
    cyc();
    drv(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic pair(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    @(negedge clk);
    drv(0, 1'b1, 1'b0, a0, '0);
    drv(1, 1'b1, 1'b0, a1, '0);
    cyc();
    drv(0, 1'b0, 1'b0, '0, '0);
    drv(1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    drv(0, 1'b0, 1'b0, '0, '0);
    drv(1, 1'b0, 1'b0, '0, '0);
    #3;
    chk("rst_p0", ob(0), ex(0, 0, 0, 8'h00));
    chk("rst_p1", ob(1), ex(0, 0, 0, 8'h00));
    repeat (2) cyc();
    @(negedge clk) reset = 1'b1;

    // ROM read, two-cycle latency then back to idle
    access(0, 1'b0, 32'h10, 8'h00);
    chk("rom_busy", ob(0), ex(1, 0, 0, 8'h00));
    cyc();
    chk("rom_done", ob(0), ex(0, 1, 0, 8'h10));
    cyc();
    chk("rom_idle", ob(0), ex(0, 0, 0, 8'h10));

    // Port 1 write to RAM then port 0 reads it back
    access(1, 1'b0, 32'h33, 8'h00);
    cyc();
    chk("p1_rom33", ob(1), ex(0, 1, 0, 8'h33));
    cyc();
    access(1, 1'b1, 32'h105, 8'hA5);
    chk("wr_busy", ob(1), ex(1, 0, 0, 8'h33));
    cyc();
    chk("wr_done", ob(1), ex(0, 1, 0, 8'h33));
    cyc();
    access(0, 1'b0, 32'h105, 8'h00);
    cyc();
    chk("rd_105", ob(0), ex(0, 1, 0, 8'hA5));
    cyc();

    // Contention: fresh reset puts port 0 first
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    pair(32'h105, 32'h100);
    chk("arb1_p0_busy", ob(0), ex(1, 0, 0, 8'h00));
    chk("arb1_p1_busy", ob(1), ex(1, 0, 0, 8'h00));
    cyc();
    chk("arb1_p0_done", ob(0), ex(0, 1, 0, 8'hA5));
    chk("arb1_p1_wait", ob(1), ex(1, 0, 0, 8'h00));
    cyc();
    chk("arb1_p0_idle", ob(0), ex(0, 0, 0, 8'hA5));
    chk("arb1_p1_done", ob(1), ex(0, 1, 0, 8'h00));
    cyc();
    // Port 0 wins a lone RAM read, so the next tie goes to port 1
    access(0, 1'b0, 32'h101, 8'h00);
    cyc();
    chk("lone_p0", ob(0), ex(0, 1, 0, 8'h00));
    cyc();
    pair(32'h105, 32'h105);
    cyc();
    chk("arb2_p1_done", ob(1), ex(0, 1, 0, 8'hA5));
    chk("arb2_p0_wait", ob(0), ex(1, 0, 0, 8'h00));
    cyc();
    chk("arb2_p0_done", ob(0), ex(0, 1, 0, 8'hA5));
    cyc();

    // Faults and map boundaries
    access(0, 1'b1, 32'h20, 8'h5A);
    chk("romwr_fault", ob(0), ex(0, 1, 1, 8'hA5));
    cyc();
    chk("romwr_idle", ob(0), ex(0, 0, 1, 8'hA5));
    access(0, 1'b0, 32'h20, 8'h00);
    chk("fault_hold", ob(0), ex(1, 0, 1, 8'hA5));
    cyc();
    chk("rom20_intact", ob(0), ex(0, 1, 0, 8'h20));
    cyc();
    access(0, 1'b0, 32'h300, 8'h00);
    chk("oob_300", ob(0), ex(0, 1, 1, 8'h20));
    cyc();
    access(0, 1'b0, 32'h2FF, 8'h00);
    chk("top_busy", ob(0), ex(1, 0, 1, 8'h20));
    cyc();
    chk("top_2ff", ob(0), ex(0, 1, 0, 8'h00));
    cyc();

    // Reset during an ungranted RAM write
    access(1, 1'b1, 32'h180, 8'h3C);
    cyc();
    chk("wr180", ob(1), ex(0, 1, 0, 8'hA5));
    cyc();
    access(1, 1'b0, 32'h44, 8'h00);
    cyc();
    chk("rom44", ob(1), ex(0, 1, 0, 8'h44));
    cyc();
    access(1, 1'b0, 32'h400, 8'h00);
    chk("oob_400", ob(1), ex(0, 1, 1, 8'h44));
    cyc();
    access(1, 1'b1, 32'h180, 8'h77);
    chk("abort_busy", ob(1), ex(1, 0, 1, 8'h44));
    #2 reset = 1'b0;
    #1;
    chk("async_p1", ob(1), ex(0, 0, 0, 8'h00));
    chk("async_p0", ob(0), ex(0, 0, 0, 8'h00));
    repeat (2) cyc();
    @(negedge clk) reset = 1'b1;
    access(0, 1'b0, 32'h180, 8'h00);
    cyc();
    chk("rd180_old", ob(0), ex(0, 1, 0, 8'h3C));
    cyc();

    // Back-to-back ROM reads with req held; addr changes while busy ignored
    @(negedge clk) drv(0, 1'b1, 1'b0, 32'h01, 8'h00);
    cyc();
    chk("bb_e0", ob(0), ex(1, 0, 0, 8'h3C));
    drv(0, 1'b1, 1'b0, 32'h02, 8'h00);
    cyc();
    chk("bb_e1", ob(0), ex(0, 1, 0, 8'h01));
    cyc();
    chk("bb_e2", ob(0), ex(1, 0, 0, 8'h01));
    drv(0, 1'b1, 1'b0, 32'h03, 8'h00);
    cyc();
    chk("bb_e3", ob(0), ex(0, 1, 0, 8'h02));
    cyc();
    chk("bb_e4", ob(0), ex(1, 0, 0, 8'h02));
    cyc();
    chk("bb_e5", ob(0), ex(0, 1, 0, 8'h03));
    drv(0, 1'b0, 1'b0, '0, '0);
    cyc();
    chk("bb_e6", ob(0), ex(0, 0, 0, 8'h03));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
